// File: rtl/clock_set_ctrl.sv
// Button-driven sequencer for the alarm clock core: owns the set-time and alarm
// digit registers, gates the core enable, strobes time loads and runs ring/snooze.
module clock_set_ctrl #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_MIN = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       minute_tick,
    input  logic       alarm_hit,
    output logic [1:0] h1,
    output logic [4:0] h2,
    output logic [3:0] m1,
    output logic [4:0] m2,
    output logic [1:0] hA1,
    output logic [4:0] hA2,
    output logic [3:0] mA1,
    output logic [4:0] mA2,
    output logic       time_load,
    output logic       run_en,
    output logic       alarm_armed,
    output logic       alarm_on
);

    typedef enum logic [2:0] {RUN, SET_TH, SET_TM, SET_AH, SET_AM, RING, SNOOZE} state_t;

    state_t     state;
    logic [5:0] cnt;
    logic [1:0] th_t, ah_t;
    logic [3:0] th_u, tm_u, ah_u, am_u;
    logic [2:0] tm_t, am_t;

    // BCD 24 h hour step, packed {tens, units}
    function automatic logic [5:0] hr_inc(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd2 && u == 4'd3) return 6'd0;
        else if (u == 4'd9)         return {t + 2'd1, 4'd0};
        else                        return {t, u + 4'd1};
    endfunction

    // BCD minute step, wraps 59 -> 00 without carrying into the hour
    function automatic logic [6:0] mn_inc(input logic [2:0] t, input logic [3:0] u);
        if (t == 3'd5 && u == 4'd9) return 7'd0;
        else if (u == 4'd9)         return {t + 3'd1, 4'd0};
        else                        return {t, u + 4'd1};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            th_t        <= '0;
            th_u        <= '0;
            tm_t        <= '0;
            tm_u        <= '0;
            ah_t        <= '0;
            ah_u        <= '0;
            am_t        <= '0;
            am_u        <= '0;
            alarm_armed <= 1'b0;
            time_load   <= 1'b0;
            run_en      <= 1'b1;
            alarm_on    <= 1'b0;
        end else begin
            time_load <= 1'b0;
            case (state)
                RUN: begin
                    if (btn_mode) begin
                        state  <= SET_TH;
                        run_en <= 1'b0;
                    end else if (btn_snooze) begin
                        alarm_armed <= ~alarm_armed;
                    end else if (alarm_hit && alarm_armed) begin
                        state    <= RING;
                        cnt      <= '0;
                        alarm_on <= 1'b1;
                    end
                end
                SET_TH: begin
                    if (btn_mode)     state <= SET_TM;
                    else if (btn_inc) {th_t, th_u} <= hr_inc(th_t, th_u);
                end
                SET_TM: begin
                    if (btn_mode) begin
                        state     <= SET_AH;
                        run_en    <= 1'b1;
                        time_load <= 1'b1;
                    end else if (btn_inc) begin
                        {tm_t, tm_u} <= mn_inc(tm_t, tm_u);
                    end
                end
                SET_AH: begin
                    if (btn_mode)     state <= SET_AM;
                    else if (btn_inc) {ah_t, ah_u} <= hr_inc(ah_t, ah_u);
                end
                SET_AM: begin
                    if (btn_mode)     state <= RUN;
                    else if (btn_inc) {am_t, am_u} <= mn_inc(am_t, am_u);
                end
                RING: begin
                    if (btn_mode) begin
                        state    <= RUN;
                        alarm_on <= 1'b0;
                    end else if (btn_snooze) begin
                        state    <= SNOOZE;
                        cnt      <= 6'(SNOOZE_MIN);
                        alarm_on <= 1'b0;
                    end else if (minute_tick) begin
                        cnt <= cnt + 6'd1;
                        if (cnt + 6'd1 == 6'(RING_MAX_MIN)) begin
                            state    <= RUN;
                            alarm_on <= 1'b0;
                        end
                    end
                end
                SNOOZE: begin
                    if (btn_mode) begin
                        state <= RUN;
                    end else if (minute_tick) begin
                        if (cnt <= 6'd1) begin
                            state    <= RING;
                            cnt      <= '0;
                            alarm_on <= 1'b1;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    state    <= RUN;
                    run_en   <= 1'b1;
                    alarm_on <= 1'b0;
                end
            endcase
        end
    end

    assign h1  = th_t;
    assign h2  = {1'b0, th_u};
    assign m1  = {1'b0, tm_t};
    assign m2  = {1'b0, tm_u};
    assign hA1 = ah_t;
    assign hA2 = {1'b0, ah_u};
    assign mA1 = {1'b0, am_t};
    assign mA2 = {1'b0, am_u};

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed vector table, corner-case
// sequences and randomized buttons against an integer-arithmetic reference model.
module tb_clock_set_ctrl;

    localparam int SN = 5;
    localparam int RM = 10;

    logic       clk = 1'b0;
    logic       reset, btn_mode, btn_inc, btn_snooze, minute_tick, alarm_hit;
    logic [1:0] h1, hA1;
    logic [4:0] h2, m2, hA2, mA2;
    logic [3:0] m1, mA1;
    logic       time_load, run_en, alarm_armed, alarm_on;

    clock_set_ctrl #(.SNOOZE_MIN(SN), .RING_MAX_MIN(RM)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_snooze(btn_snooze), .minute_tick(minute_tick), .alarm_hit(alarm_hit),
        .h1(h1), .h2(h2), .m1(m1), .m2(m2), .hA1(hA1), .hA2(hA2), .mA1(mA1), .mA2(mA2),
        .time_load(time_load), .run_en(run_en), .alarm_armed(alarm_armed), .alarm_on(alarm_on)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: times as plain integers, modes as small codes
    localparam int M_RUN = 0, M_TH = 1, M_TM = 2, M_AH = 3, M_AM = 4, M_RING = 5, M_SNZ = 6;
    int mst, thr, tmn, ahr, amn, marm, mcnt, mtl;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [35:0] dut_vec();
        return {h1, h2, m1, m2, hA1, hA2, mA1, mA2, time_load, run_en, alarm_armed, alarm_on};
    endfunction

    function automatic logic [35:0] model_vec();
        return {2'(thr / 10), 5'(thr % 10), 4'(tmn / 10), 5'(tmn % 10),
                2'(ahr / 10), 5'(ahr % 10), 4'(amn / 10), 5'(amn % 10),
                1'(mtl), 1'(!(mst == M_TH || mst == M_TM)), 1'(marm), 1'(mst == M_RING)};
    endfunction

    task automatic model(input bit rst, md, sz, inc, tk, hit);
        mtl = 0;
        if (rst) begin
            mst = M_RUN; thr = 0; tmn = 0; ahr = 0; amn = 0; marm = 0; mcnt = 0;
        end else begin
            case (mst)
                M_RUN:  if (md) mst = M_TH;
                        else if (sz) marm = 1 - marm;
                        else if (hit && marm == 1) begin mst = M_RING; mcnt = 0; end
                M_TH:   if (md) mst = M_TM; else if (inc) thr = (thr + 1) % 24;
                M_TM:   if (md) begin mst = M_AH; mtl = 1; end else if (inc) tmn = (tmn + 1) % 60;
                M_AH:   if (md) mst = M_AM; else if (inc) ahr = (ahr + 1) % 24;
                M_AM:   if (md) mst = M_RUN; else if (inc) amn = (amn + 1) % 60;
                M_RING: if (md) mst = M_RUN;
                        else if (sz) begin mst = M_SNZ; mcnt = SN; end
                        else if (tk) begin mcnt++; if (mcnt == RM) mst = M_RUN; end
                M_SNZ:  if (md) mst = M_RUN;
                        else if (tk) begin mcnt--; if (mcnt == 0) mst = M_RING; end
                default: mst = M_RUN;
            endcase
        end
    endtask

    // one clock with the given inputs, then compare every output to the model
    task automatic step(input bit rst, md, sz, inc, tk, hit, input string nm);
        reset = rst; btn_mode = md; btn_snooze = sz; btn_inc = inc;
        minute_tick = tk; alarm_hit = hit;
        @(posedge clk);
        #1;
        model(rst, md, sz, inc, tk, hit);
        chk(nm, 64'(dut_vec()), 64'(model_vec()));
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, "reset");
    endtask

    typedef struct {
        bit md, sz, inc, tk, hit;
        bit e_run, e_on, e_arm, e_tl;
        int e_hr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // {mode, snooze, inc, tick, hit} -> {run_en, alarm_on, armed, time_load, hour}
        tbl[0]  = '{0,0,0,0,0, 1,0,0,0, 0};  // idle after reset
        tbl[1]  = '{0,0,0,0,1, 1,0,0,0, 0};  // hit while disarmed
        tbl[2]  = '{0,1,0,0,0, 1,0,1,0, 0};  // arm
        tbl[3]  = '{0,0,1,0,1, 1,1,1,0, 0};  // inc is inert in RUN, hit rings
        tbl[4]  = '{0,0,0,1,0, 1,1,1,0, 0};  // ring counts 1
        tbl[5]  = '{1,1,0,1,0, 1,0,1,0, 0};  // mode beats snooze and tick
        tbl[6]  = '{0,1,0,0,1, 1,0,0,0, 0};  // snooze acts, hit dropped
        tbl[7]  = '{0,0,0,0,1, 1,0,0,0, 0};  // disarmed again
        tbl[8]  = '{1,0,0,0,0, 0,0,0,0, 0};  // SET_TH
        tbl[9]  = '{0,0,1,0,0, 0,0,0,0, 1};
        tbl[10] = '{0,0,1,0,0, 0,0,0,0, 2};
        tbl[11] = '{1,0,0,0,0, 0,0,0,0, 2};  // SET_TM
        tbl[12] = '{1,0,0,0,0, 1,0,0,1, 2};  // SET_AH with load strobe
        tbl[13] = '{0,0,0,0,1, 1,0,0,0, 2};  // hit ignored outside RUN
        tbl[14] = '{1,0,0,0,0, 1,0,0,0, 2};  // SET_AM
        tbl[15] = '{1,0,0,0,0, 1,0,0,0, 2};  // RUN

        do_reset();
        chk("reset_state", 64'(dut_vec()), 64'({32'd0, 4'b0100}));
        for (int i = 0; i < 16; i++) begin
            step(0, tbl[i].md, tbl[i].sz, tbl[i].inc, tbl[i].tk, tbl[i].hit, $sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_flags", i), 64'({run_en, alarm_on, alarm_armed, time_load}),
                64'({tbl[i].e_run, tbl[i].e_on, tbl[i].e_arm, tbl[i].e_tl}));
            chk($sformatf("tbl%0d_hour", i), 64'(h1 * 10 + h2), 64'(tbl[i].e_hr));
        end

        // hour wrap 23 -> 00 and minute wrap 59 -> 00 without hour carry
        do_reset();
        step(0, 1, 0, 0, 0, 0, "enter_th");
        for (int i = 0; i < 23; i++) step(0, 0, 0, 1, 0, 0, "hr_inc");
        chk("hour_23", 64'({h1, h2}), 64'({2'd2, 5'd3}));
        step(0, 0, 0, 1, 0, 0, "hr_wrap");
        chk("hour_00", 64'({h1, h2}), 64'd0);
        step(0, 1, 0, 0, 0, 0, "enter_tm");
        for (int i = 0; i < 60; i++) step(0, 0, 0, 1, 0, 0, "mn_inc");
        chk("min_wrap", 64'({h1, h2, m1, m2, run_en}), 64'd0);

        // set 07:30 and leave SET_TM
        do_reset();
        step(0, 1, 0, 0, 0, 0, "enter_th");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, "hr_inc");
        step(0, 1, 0, 0, 0, 0, "enter_tm");
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0, 0, "mn_inc");
        chk("run_en_in_tm", 64'(run_en), 64'd0);
        step(0, 1, 0, 0, 0, 0, "exit_tm");
        chk("load_0730", 64'({h1, h2, m1, m2, time_load, run_en}),
            64'({2'd0, 5'd7, 4'd3, 5'd0, 1'b1, 1'b1}));
        step(0, 0, 0, 0, 0, 0, "after_load");
        chk("load_one_cycle", 64'({time_load, h1, h2, m1, m2}), 64'({1'b0, 2'd0, 5'd7, 4'd3, 5'd0}));
        step(0, 1, 0, 0, 0, 0, "to_am");
        step(0, 1, 0, 0, 0, 0, "to_run");

        // ring, snooze 5 minutes, then 10-minute auto-silence
        step(0, 0, 1, 0, 0, 0, "arm");
        step(0, 0, 0, 0, 0, 1, "hit");
        chk("ring_on", 64'(alarm_on), 64'd1);
        step(0, 0, 1, 0, 0, 0, "snooze");
        chk("snooze_off", 64'(alarm_on), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0, "snz_tick");
            chk("snz_quiet", 64'(alarm_on), 64'd0);
        end
        step(0, 0, 0, 0, 1, 0, "snz_tick5");
        chk("re_ring", 64'(alarm_on), 64'd1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 0, "ring_tick");
        chk("ring_9", 64'(alarm_on), 64'd1);
        step(0, 0, 0, 0, 1, 0, "ring_tick10");
        chk("ring_timeout", 64'({alarm_on, run_en}), 64'({1'b0, 1'b1}));

        // all three inputs in RING: dismiss
        step(0, 0, 0, 0, 0, 1, "hit2");
        step(0, 1, 1, 0, 1, 0, "dismiss");
        chk("dismiss", 64'(alarm_on), 64'd0);

        // reset while editing the alarm minute
        step(0, 1, 0, 0, 0, 0, "th");
        step(0, 0, 0, 1, 0, 0, "th_inc");
        step(0, 1, 0, 0, 0, 0, "tm");
        step(0, 1, 0, 0, 0, 0, "ah");
        step(0, 0, 0, 1, 0, 0, "ah_inc");
        step(0, 1, 0, 0, 0, 0, "am");
        step(0, 0, 0, 1, 0, 0, "am_inc");
        step(1, 1, 0, 1, 0, 0, "reset_mid_am");
        chk("reset_mid_am", 64'(dut_vec()), 64'({32'd0, 4'b0100}));
        step(0, 1, 0, 0, 0, 0, "reset_went_run");
        chk("reset_went_run", 64'(run_en), 64'd0);

        // randomized buttons against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit r, md, sz, inc, tk, hit;
            r   = ($urandom_range(0, 299) == 0);
            md  = ($urandom_range(0, 11) == 0);
            sz  = ($urandom_range(0, 9) == 0);
            inc = ($urandom_range(0, 2) == 0);
            tk  = ($urandom_range(0, 3) == 0);
            hit = ($urandom_range(0, 7) == 0);
            if (mst >= M_TH && mst <= M_AM && inc) sz = 0;
            step(r, md, sz, inc, tk, hit, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven controller that sequences the alarm clock datapath. It owns the user-editable set-time and alarm digit registers and presents them to the alarm clock core's set-time and alarm inputs. It gates the core's `enable`, issues a load strobe for the set time, and runs the ring/snooze/dismiss state machine whose `alarm_on` output gates the speaker.

## Interface
Parameters:
- `SNOOZE_MIN`, default 5: minutes from snooze press to re-ring. Legal range 1..63.
- `RING_MAX_MIN`, default 10: minutes of unattended ringing before auto-silence. Legal range 1..63.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_mode` in 1: one-cycle pulse, debounced upstream.
- `btn_inc` in 1: one-cycle pulse, debounced upstream.
- `btn_snooze` in 1: one-cycle pulse, debounced upstream.
- `minute_tick` in 1: one-cycle pulse per elapsed minute, from the timebase.
- `alarm_hit` in 1: one-cycle pulse when the core's time equals the alarm time.
- `h1` out 2: set-time hour tens (0..2).
- `h2` out 5: set-time hour units (0..9).
- `m1` out 4: set-time minute tens (0..5).
- `m2` out 5: set-time minute units (0..9).
- `hA1`, `hA2`, `mA1`, `mA2` out 2/5/4/5: alarm digits, same encoding as the set-time digits.
- `time_load` out 1: one-cycle strobe; the core copies `h1..m2` into its running time.
- `run_en` out 1: drives the core's `enable`.
- `alarm_armed` out 1: alarm enabled (indicator).
- `alarm_on` out 1: speaker gate.

## Operation
- States: RUN, SET_TH, SET_TM, SET_AH, SET_AM, RING, SNOOZE.
- Input priority within a cycle: `btn_mode` > `btn_snooze` > `btn_inc`. Only the highest-priority active button has any effect.
- RUN:
  - `btn_mode` → SET_TH.
  - `btn_snooze` toggles `alarm_armed`.
  - `alarm_hit` with `alarm_armed`=1 → RING, and the ring counter is cleared. If a button acts in the same cycle, the button wins and `alarm_hit` is dropped.
- SET_TH: `btn_inc` increments the set-time hour. `btn_mode` → SET_TM.
- SET_TM: `btn_inc` increments the set-time minute. `btn_mode` → SET_AH and pulses `time_load`.
- SET_AH: `btn_inc` increments the alarm hour. `btn_mode` → SET_AM.
- SET_AM: `btn_inc` increments the alarm minute. `btn_mode` → RUN.
- RING:
  - `btn_mode` → RUN (dismiss).
  - `btn_snooze` → SNOOZE and loads the counter with `SNOOZE_MIN`.
  - Each `minute_tick` increments the ring counter. When it reaches `RING_MAX_MIN` → RUN.
- SNOOZE:
  - `btn_mode` → RUN (cancel).
  - Each `minute_tick` decrements the counter. The tick that takes it to 0 → RING, and the ring counter is cleared.
- `alarm_hit` is ignored in every state other than RUN. `btn_snooze` is ignored in all SET states. `btn_inc` is ignored outside the SET states.
- Hour increment (BCD, 24 h):
  - 23 → 00.
  - Otherwise, units 9 → units 0 and tens+1.
  - Otherwise units+1.
- Minute increment:
  - 59 → 00, with no carry into hours.
  - Otherwise, units 9 → units 0 and tens+1.
  - Otherwise units+1.
- Digit registers never hold an out-of-range value.
- Alarm digits change only in SET_AH/SET_AM. Set-time digits change only in SET_TH/SET_TM.
- `run_en` = 0 in SET_TH and SET_TM, 1 in all other states. The clock keeps running while the alarm is being edited.
- `alarm_on` = 1 only in RING.
- Counter: 6 bits, shared between ring and snooze.

## Timing
- All outputs are registered and change on the edge that samples the causing input, so they are visible one cycle after the input pulse.
- `time_load` is high for exactly the one cycle in which the state first reads SET_AH. `h1..m2` are stable during that cycle and for the entire SET_AH/SET_AM/RUN period that follows.
- A digit increment is visible one cycle after `btn_inc`. Back-to-back `btn_inc` pulses each increment.
- `alarm_on` rises one cycle after an accepted `alarm_hit` and falls one cycle after dismiss, snooze or timeout.
- Reset, from any state including mid-edit or mid-ring:
  - Next state is RUN.
  - All digits are 0 (00:00 time and alarm).
  - `alarm_armed`=0, counter=0, `time_load`=0, `alarm_on`=0, `run_en`=1.
  - Reset overrides all inputs in the same cycle.

## Test plan
- Reset, then idle → all digits 0, `run_en`=1, `alarm_on`=0, `alarm_armed`=0, `time_load` never asserted.
- `btn_mode`, then 23×`btn_inc`, then 1 more `btn_inc` → hour reads 23 and then 00. Next `btn_mode`, then 60×`btn_inc` → minute wraps back to 00 with hour unchanged. `run_en`=0 throughout the time edit.
- Set time to 07:30 and exit SET_TM → `time_load` high for one cycle with `h1`=0, `h2`=7, `m1`=3, `m2`=0, and `run_en` returns to 1 in that same cycle.
- `alarm_armed`=0, pulse `alarm_hit` → stays in RUN. Press `btn_snooze` (armed=1), pulse `alarm_hit` → `alarm_on`=1 on the next cycle.
- In RING press `btn_snooze`, then apply 4 `minute_tick`s → `alarm_on` stays 0. The 5th tick → `alarm_on`=1. Then 10 ticks → `alarm_on`=0 and state RUN.
- In RING, apply `btn_mode`, `btn_snooze` and `minute_tick` in the same cycle → dismiss to RUN. Assert `reset` mid-SET_AM → all digits 00, state RUN, no `time_load`.
